// File: rtl/pixel_word_packer_if.sv
// Pixel-in / word-out bundle between the capture path, the packer and the write engine.
// The slave modport is the packer's view; the master modport is the driving side.
interface pixel_word_packer_if #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
);
    logic [7:0]    iPix;
    logic          iPixValid;
    logic          iFrameStart;
    logic          iFlush;
    logic          iReady;
    logic [31:0]   oData;
    logic          oValid;
    logic [LW-1:0] oLevel;
    logic          oOverflow;

    modport slave (
        input  iPix, iPixValid, iFrameStart, iFlush, iReady,
        output oData, oValid, oLevel, oOverflow
    );

    modport master (
        output iPix, iPixValid, iFrameStart, iFlush, iReady,
        input  oData, oValid, oLevel, oOverflow
    );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs 8-bit pixels into 32-bit little-endian words, queues them in a FIFO and
// holds each word in an output register until the write engine accepts it.
module pixel_word_packer #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input logic                 ctrl_clk,
    input logic                 reset_n,
    pixel_word_packer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Packer state
    logic [1:0]    r_lane;
    logic [23:0]   r_acc;
    logic [1:0]    w_lane_next;
    logic [23:0]   w_acc_next;
    logic [23:0]   w_acc_ins;
    logic          w_push;
    logic [31:0]   w_push_data;

    // FIFO state
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_accept;
    logic          w_push_ok;

    // Output register state
    out_state_t    r_state;
    logic [31:0]   r_data;
    logic          r_valid;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_lane_next = r_lane;
        w_acc_next  = r_acc;
        w_push      = 1'b0;
        w_push_data = '0;
        w_acc_ins   = r_acc;
        // Lane 0 clears the upper lanes, so a later flush pads with zeros for free.
        case (r_lane)
            2'd0:    w_acc_ins = {16'h0, bus.iPix};
            2'd1:    w_acc_ins[15:8]  = bus.iPix;
            2'd2:    w_acc_ins[23:16] = bus.iPix;
            default: w_acc_ins = r_acc;
        endcase

        if (bus.iFrameStart) begin
            w_lane_next = bus.iPixValid ? 2'd1 : 2'd0;
            w_acc_next  = bus.iPixValid ? {16'h0, bus.iPix} : 24'h0;
        end else if (bus.iPixValid) begin
            if (r_lane == 2'd3) begin
                w_push      = 1'b1;
                w_push_data = {bus.iPix, r_acc};
                w_lane_next = 2'd0;
            end else if (bus.iFlush) begin
                w_push      = 1'b1;
                w_push_data = {8'h0, w_acc_ins};
                w_lane_next = 2'd0;
            end else begin
                w_acc_next  = w_acc_ins;
                w_lane_next = r_lane + 2'd1;
            end
        end else if (bus.iFlush && (r_lane != 2'd0)) begin
            w_push      = 1'b1;
            w_push_data = {8'h0, r_acc};
            w_lane_next = 2'd0;
        end
    end

    assign w_full    = (r_count == LW'(DEPTH));
    assign w_accept  = (r_state == ST_FULL) && bus.iReady;
    assign w_pop     = ((r_state == ST_EMPTY) || w_accept) && (r_count != '0);
    assign w_push_ok = w_push && (!w_full || w_pop);

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ctrl_clk) begin
        if (!reset_n) begin
            r_lane <= 2'd0;
            r_acc  <= 24'h0;
        end else begin
            r_lane <= w_lane_next;
            r_acc  <= w_acc_next;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge ctrl_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge ctrl_clk) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + LW'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - LW'(1);
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // A pop on a full FIFO reads the old entry even if the write lands on the same address.
    always_ff @(posedge ctrl_clk) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
            r_data  <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_pop) begin
                        r_state <= ST_FULL;
                        r_data  <= r_mem[r_rptr];
                        r_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (bus.iReady) begin
                        if (w_pop) begin
                            r_data <= r_mem[r_rptr];
                        end else begin
                            r_state <= ST_EMPTY;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oData     = r_data;
    assign bus.oValid    = r_valid;
    assign bus.oLevel    = r_count;
    assign bus.oOverflow = r_overflow;
endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Packs the 8-bit pixel stream from the capture path into 32-bit little-endian words. It buffers them in a small FIFO and presents them one at a time to the Avalon write engine in the bus block. That engine writes one word per transaction, raises `write` for at least two cycles per word and exports no back pressure upstream. This block absorbs `write_waitrequest` stalls and holds `oData` stable until the engine accepts the word.

## Interface
- `DEPTH`, 16: FIFO depth in 32-bit words; power of 2, minimum 4.
- `LW`, `$clog2(DEPTH)+1`: width of `oLevel`.

Ports:
- `ctrl_clk`  in  1  clock; all logic on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `iPix`  in  8  pixel data.
- `iPixValid`  in  1  pixel qualifier; `iPix` is sampled when high.
- `iFrameStart`  in  1  one-cycle pulse; discards any partial word and re-aligns packing to lane 0.
- `iFlush`  in  1  one-cycle pulse; zero-pads the partial word and pushes it.
- `iReady`  in  1  downstream write engine is idle and accepts `oData` this cycle.
- `oData`  out  32  packed word; stable while `oValid`=1 and not accepted.
- `oValid`  out  1  `oData` holds a word.
- `oLevel`  out  LW  words in the FIFO, excluding the output register.
- `oOverflow`  out  1  sticky; set when a word is dropped because the FIFO is full.

## Operation
Packer:
- 2-bit lane counter `lane` plus a 24-bit accumulator.
- Pixel *k* of a group goes to bits [8k+7:8k]. The first pixel after reset or frame start occupies [7:0].
- When `iPixValid` is high and `lane`=3, the word {iPix, acc[23:0]} is pushed that cycle and `lane` wraps to 0. Otherwise `lane` increments.
- `iFrameStart`: `lane` is set to 0 and the accumulator contents are discarded. If `iPixValid` is high in the same cycle, that pixel is lane 0 of the new word.
- `iFlush` with `lane`≠0: pushes the accumulator with unfilled lanes zero, and `lane` is set to 0.
  - With `lane`=0 and no valid pixel, `iFlush` does nothing.
  - If `iFlush` and `iPixValid` are high together, the pixel is included first, and the word is then pushed padded. If that pixel completes the word, only that one word is pushed.
  - `iFrameStart` takes priority over `iFlush`.

FIFO:
- Synchronous, DEPTH entries, with binary read and write pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH.
- The count register drives `oLevel`.
- Pop occurs when the output register is empty, or is being accepted this cycle, and `oLevel`>0.
- Push while full:
  - With a pop in the same cycle, the push is accepted and `oLevel` is unchanged.
  - Without a pop, the word is dropped, `oOverflow` is set to 1, and the pointers are unchanged.
- Push and pop together at any other level: `oLevel` is unchanged.

Output register (states EMPTY / FULL):
- EMPTY→FULL on pop. `oValid`=1 and `oData` is the FIFO word.
- FULL with `iReady`=1: the word is accepted. The state stays FULL if a pop occurs the same cycle, otherwise it goes to EMPTY.
- FULL with `iReady`=0: the state and `oData` hold.
- `iReady` while EMPTY is ignored.

Reset: while `reset_n`=0 at an edge, the following are cleared and any partial word is lost:
- `lane`, accumulator and pointers: 0
- `oLevel`: 0
- `oValid`: 0
- `oData`: 32'h0
- `oOverflow`: 0

## Timing
- Latency: with the FIFO and output register empty, a 4th pixel sampled at edge N gives a FIFO write at edge N. `oValid` rises after edge N+1, so it is visible in the cycle following edge N+1. The data path is a flat 2 cycles.
- Throughput: one push per cycle maximum, because a pushed word needs 4 pixels or a flush. One accept per cycle maximum.
- The downstream engine asserts `iReady` only in its idle state. The sustained drain rate is therefore one word per ≥2 cycles, against a full-rate fill rate of one word per 4 cycles.
- `oData` may change only on the edge that completes an accept, or on EMPTY→FULL.
- All outputs are registered, with no combinational path from any input.

## Test plan
- Reset, then pixels 0x11,0x22,0x33,0x44 on consecutive cycles with `iReady`=1 → `oData`=32'h44332211 and `oValid` 2 cycles after the 4th pixel; `oLevel` returns to 0.
- 0xAA,0xBB, then `iFlush` → word 32'h0000BBAA. A following group 1,2,3,4 → 32'h04030201, correctly aligned.
- 0x01,0x02, then `iFrameStart` with `iPixValid` and 0x10, then 0x20,0x30,0x40 → only 32'h40302010 is produced; `oLevel` never counts the partial word.
- `iReady`=0 for 100 cycles with 4·(DEPTH+2) pixels → `oLevel`=DEPTH, `oValid`=1, the first word is held stable and `oOverflow`=1. Then `iReady`=1 → exactly DEPTH+1 words drain in order.
- With the FIFO full, a push on the same cycle as an accept → no drop and `oOverflow` remains 0. Pulse `reset_n` low while FULL → all outputs return to their reset values the next cycle.
- Random `iPixValid` and `iReady` (~50%) over 4096 pixels against a scoreboard model → identical word sequence, no `oData` change while held, and `oOverflow`=0.
